// File: rtl/clock_div_if.sv
// rtl/clock_div_if.sv - divided-clock output bundle for clock_div
`timescale 1ns/1ps

interface clock_div_if;
    logic slow_clk;

    modport master (output slow_clk);
    modport slave  (input  slow_clk);
endinterface

// File: rtl/clock_div.sv
// rtl/clock_div.sv - integer clock divider, 50% duty for even div, half-cycle balanced for odd div
`timescale 1ns/1ps

module clock_div #(
    parameter int div = 5
) (
    input  logic        clk,
    input  logic        rst,
    clock_div_if.master out_if
);

    localparam int half = div / 2;
    localparam int cw   = (div > 1) ? $clog2(div) : 1;

    if (div < 1 || div > 65535) begin : g_bad_div
        $error("clock_div: div must be in 1..65535");
    end

    if (div == 1) begin : g_bypass
        assign out_if.slow_clk = clk & ~rst;
    end else begin : g_divide
        logic [cw-1:0] cnt;
        logic [cw-1:0] cnt_next;
        logic          q_p;

        always_comb begin
            cnt_next = cnt + cw'(1);
            if (cnt == cw'(div - 1)) begin
                cnt_next = '0;
            end
        end

        // q_p tracks the upper half of the count so it is already aligned to the new cnt
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
                q_p <= 1'b0;
            end else begin
                cnt <= cnt_next;
                q_p <= (cnt_next >= cw'(half));
            end
        end

        if (div % 2 == 0) begin : g_even
            assign out_if.slow_clk = q_p;
        end else begin : g_odd
            logic q_n;

            // Delaying the rise by half a cycle balances high and low time around div/2
            always_ff @(negedge clk or posedge rst) begin
                if (rst) begin
                    q_n <= 1'b0;
                end else begin
                    q_n <= q_p;
                end
            end

            assign out_if.slow_clk = q_p & q_n;
        end
    end

endmodule

// File: tb/tb_clock_div.sv
// tb/tb_clock_div.sv - self-checking bench for clock_div across several divisors
`timescale 1ns/1ps

module tb_clock_div;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   pcount;
    bit   rec;
    time  r5[$];
    time  f5[$];
    time  r4[$];
    time  f4[$];

    clock_div_if if1 ();
    clock_div_if if2 ();
    clock_div_if if3 ();
    clock_div_if if4 ();
    clock_div_if if5 ();
    clock_div_if if16 ();

    clock_div #(.div(1))  u_d1  (.clk(clk), .rst(rst), .out_if(if1));
    clock_div #(.div(2))  u_d2  (.clk(clk), .rst(rst), .out_if(if2));
    clock_div #(.div(3))  u_d3  (.clk(clk), .rst(rst), .out_if(if3));
    clock_div #(.div(4))  u_d4  (.clk(clk), .rst(rst), .out_if(if4));
    clock_div #(.div(5))  u_d5  (.clk(clk), .rst(rst), .out_if(if5));
    clock_div #(.div(16)) u_d16 (.clk(clk), .rst(rst), .out_if(if16));

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Rising clk edges seen since the most recent reset release
    always @(posedge clk or posedge rst) begin
        if (rst) pcount <= 0;
        else     pcount <= pcount + 1;
    end

    always @(posedge if5.slow_clk) if (rec) r5.push_back($time);
    always @(negedge if5.slow_clk) if (rec) f5.push_back($time);
    always @(posedge if4.slow_clk) if (rec) r4.push_back($time);
    always @(negedge if4.slow_clk) if (rec) f4.push_back($time);

    // Output level from position in the period: t counts half-cycles since release
    function automatic logic model(input int d, input int k, input bit h, input logic r);
        int t, ph, n;
        if (r) return 1'b0;
        if (d == 1) return (h == 1'b0);
        n  = d / 2;
        t  = 2 * k + int'(h);
        ph = t % (2 * d);
        if (d % 2 == 0) return (ph >= 2 * n);
        return (ph >= 2 * n + 1);
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
        end
    endtask

    task automatic check_t(input string tag, input time obs, input time exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0t expected %0t", tag, obs, exp);
        end
    endtask

    task automatic sample_all(input bit h);
        check("div1",  if1.slow_clk,  model(1,  pcount, h, rst));
        check("div2",  if2.slow_clk,  model(2,  pcount, h, rst));
        check("div3",  if3.slow_clk,  model(3,  pcount, h, rst));
        check("div4",  if4.slow_clk,  model(4,  pcount, h, rst));
        check("div5",  if5.slow_clk,  model(5,  pcount, h, rst));
        check("div16", if16.slow_clk, model(16, pcount, h, rst));
    endtask

    task automatic cycle();
        @(posedge clk); #5; sample_all(1'b0);
        @(negedge clk); #5; sample_all(1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_d1"},  if1.slow_clk,  1'b0);
        check({tag, "_d2"},  if2.slow_clk,  1'b0);
        check({tag, "_d3"},  if3.slow_clk,  1'b0);
        check({tag, "_d4"},  if4.slow_clk,  1'b0);
        check({tag, "_d5"},  if5.slow_clk,  1'b0);
        check({tag, "_d16"}, if16.slow_clk, 1'b0);
    endtask

    task automatic release_rst();
        @(negedge clk);
        #($urandom_range(1, 3));
        rst = 1'b0;
    endtask

    initial begin
        int  n;
        bit  found;
        vectors     = 0;
        miscompares = 0;
        rec         = 1'b0;
        rst         = 1'b1;

        #1;
        check_all_zero("reset_state");
        #2;
        rst = 1'b0;
        rec = 1'b1;
        repeat (75) cycle();
        rec = 1'b0;

        vectors++;
        assert (r5.size() >= 15 && f5.size() >= 14) else begin
            miscompares++;
            $error("FAIL div5_edge_count: observed %0d rises %0d falls expected >=15/>=14", r5.size(), f5.size());
        end
        if (r5.size() >= 1) check_t("div5_first_rise", r5[0], 40);
        if (f5.size() >= 1) check_t("div5_first_fall", f5[0], 90);
        for (int i = 1; i < 15 && i < r5.size() && i <= f5.size(); i++) begin
            check_t("div5_period", r5[i] - r5[i-1], 100);
            check_t("div5_high",   f5[i-1] - r5[i-1], 50);
        end
        if (r4.size() >= 2) check_t("div4_period", r4[1] - r4[0], 80);
        if (r4.size() >= 1) check_t("div4_first_rise", r4[0], 30);
        if (f4.size() >= 1) check_t("div4_first_fall", f4[0], 70);

        // Reset landing in the middle of a div=5 high phase
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (if5.slow_clk === 1'b1) found = 1'b1;
        end
        check("div5_high_found", found, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("mid_high_reset");
        release_rst();
        repeat (30) cycle();

        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(5, 60);
            repeat (n) cycle();
            @(posedge clk);
            #($urandom_range(1, 4));
            rst = 1'b1;
            #1;
            check_all_zero("async_reset");
            n = $urandom_range(0, 3);
            repeat (n) cycle();
            release_rst();
        end
        repeat (40) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
